// File: rtl/glove_pkg.sv
`default_nettype none
// ============================================================================
// Module      : glove_pkg
// Description : Shared UART register map, state encoding and sample type for
//               the glove acquisition front end.
// Revision    : 1.0 - initial release
// ============================================================================
package glove_pkg;

    localparam logic [4:0] RX_BASE     = 5'd0;
    localparam logic [4:0] TX_BASE     = 5'd4;
    localparam logic [4:0] STATUS_BASE = 5'd8;

    localparam int RX_OK_BIT = 7;
    localparam int TX_OK_BIT = 6;

    typedef enum logic [1:0] {
        S_QUERY_RX = 2'd0,
        S_READ_RX  = 2'd1,
        S_QUERY_TX = 2'd2,
        S_WRITE_TX = 2'd3
    } uart_state_t;

    typedef logic [15:0] sample_t;

    // Register offset each state talks to.
    function automatic logic [4:0] state_address(input uart_state_t s);
        logic [4:0] addr;
        addr = STATUS_BASE;
        case (s)
            S_READ_RX:  addr = RX_BASE;
            S_WRITE_TX: addr = TX_BASE;
            default:    addr = STATUS_BASE;
        endcase
        return addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_shift_window.sv
`default_nettype none
// ============================================================================
// Module      : sample_shift_window
// Description : Pairs bytes into big-endian samples, shifts them into a
//               sliding window and raises a strobe on first fill / stride.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_shift_window
    import glove_pkg::*;
#(
    parameter int WIN_LEN = 40,
    parameter int STRIDE  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic [7:0]               i_byte,
    input  logic                     i_byte_valid,
    output logic [0:WIN_LEN-1][15:0] o_data,
    output logic                     o_next,
    output logic                     o_full
);

    localparam int FILL_W   = $clog2(WIN_LEN + 1);
    localparam int STRIDE_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [FILL_W-1:0]   c_fill_max    = FILL_W'(WIN_LEN);
    localparam logic [FILL_W-1:0]   c_fill_last   = FILL_W'(WIN_LEN - 1);
    localparam logic [FILL_W-1:0]   c_fill_one    = FILL_W'(1);
    localparam logic [STRIDE_W-1:0] c_stride_last = STRIDE_W'(STRIDE - 1);
    localparam logic [STRIDE_W-1:0] c_stride_one  = STRIDE_W'(1);

    logic [0:WIN_LEN-1][15:0] r_win;
    logic                     r_phase;
    logic [7:0]               r_hi;
    logic [FILL_W-1:0]        r_fill_cnt;
    logic [STRIDE_W-1:0]      r_stride_cnt;
    logic                     r_next;

    sample_t w_sample;
    logic    w_sample_done;

    assign w_sample      = {r_hi, i_byte};
    assign w_sample_done = i_byte_valid & r_phase;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_win        <= '0;
            r_phase      <= 1'b0;
            r_hi         <= 8'h00;
            r_fill_cnt   <= '0;
            r_stride_cnt <= '0;
            r_next       <= 1'b0;
        end else begin
            r_next <= 1'b0;

            if (i_byte_valid) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_hi <= i_byte;
                end else begin
                    r_win <= {w_sample, r_win[0:WIN_LEN-2]};
                end
            end

            // Fill counter saturates; the stride counter only runs once full.
            if (w_sample_done) begin
                if (r_fill_cnt != c_fill_max) begin
                    r_fill_cnt <= r_fill_cnt + c_fill_one;
                    if (r_fill_cnt == c_fill_last) begin
                        r_next <= 1'b1;
                    end
                end else if (r_stride_cnt == c_stride_last) begin
                    r_stride_cnt <= '0;
                    r_next       <= 1'b1;
                end else begin
                    r_stride_cnt <= r_stride_cnt + c_stride_one;
                end
            end

            // Flush overrides counter updates but lets a completing sample shift in.
            if (i_flush) begin
                r_phase      <= 1'b0;
                r_fill_cnt   <= '0;
                r_stride_cnt <= '0;
                r_next       <= 1'b0;
            end
        end
    end

    assign o_data = r_win;
    assign o_next = r_next;
    assign o_full = (r_fill_cnt == c_fill_max);

endmodule
`default_nettype wire

// File: rtl/rs232_sample_window.sv
`default_nettype none
// ============================================================================
// Module      : rs232_sample_window
// Description : Avalon-MM master polling the RS232 UART; received bytes are
//               optionally echoed and fed to the sample window.
// Revision    : 1.0 - initial release
// ============================================================================
module rs232_sample_window
    import glove_pkg::*;
#(
    parameter int WIN_LEN = 40,
    parameter int STRIDE  = 8,
    parameter int ECHO    = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    output logic [4:0]               avm_address,
    output logic                     avm_read,
    input  logic [31:0]              avm_readdata,
    output logic                     avm_write,
    output logic [31:0]              avm_writedata,
    input  logic                     avm_waitrequest,
    input  logic                     i_flush,
    output logic [0:WIN_LEN-1][15:0] o_data,
    output logic                     o_next,
    output logic                     o_full
);

    uart_state_t r_state;
    uart_state_t w_state_nxt;

    logic [4:0] r_address;
    logic [4:0] w_address_nxt;
    logic       r_read;
    logic       w_read_nxt;
    logic       r_write;
    logic       w_write_nxt;
    logic [7:0] r_tx_byte;

    logic w_accept;
    logic w_byte_valid;
    logic w_unused_rdata;

    assign w_accept       = ~avm_waitrequest;
    assign w_byte_valid   = (r_state == S_READ_RX) && w_accept;
    assign w_unused_rdata = ^avm_readdata[31:8];

    // State and command registers; commands are loaded from the next state so
    // they stay put for as long as the slave stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_QUERY_RX;
            r_address <= STATUS_BASE;
            r_read    <= 1'b1;
            r_write   <= 1'b0;
            r_tx_byte <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_address <= w_address_nxt;
            r_read    <= w_read_nxt;
            r_write   <= w_write_nxt;
            if (w_byte_valid) begin
                r_tx_byte <= avm_readdata[7:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_QUERY_RX: begin
                if (w_accept && avm_readdata[RX_OK_BIT]) begin
                    w_state_nxt = S_READ_RX;
                end
            end
            S_READ_RX: begin
                if (w_accept) begin
                    w_state_nxt = (ECHO != 0) ? S_QUERY_TX : S_QUERY_RX;
                end
            end
            S_QUERY_TX: begin
                if (w_accept && avm_readdata[TX_OK_BIT]) begin
                    w_state_nxt = S_WRITE_TX;
                end
            end
            S_WRITE_TX: begin
                if (w_accept) begin
                    w_state_nxt = S_QUERY_RX;
                end
            end
            default: w_state_nxt = S_QUERY_RX;
        endcase
    end

    always_comb begin
        w_address_nxt = state_address(w_state_nxt);
        w_write_nxt   = (w_state_nxt == S_WRITE_TX);
        w_read_nxt    = ~w_write_nxt;
    end

    assign avm_address   = r_address;
    assign avm_read      = r_read;
    assign avm_write     = r_write;
    assign avm_writedata = {24'h000000, r_tx_byte};

    sample_shift_window #(
        .WIN_LEN (WIN_LEN),
        .STRIDE  (STRIDE)
    ) u_window (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_byte       (avm_readdata[7:0]),
        .i_byte_valid (w_byte_valid),
        .o_data       (o_data),
        .o_next       (o_next),
        .o_full       (o_full)
    );

endmodule
`default_nettype wire
